gem_match_window_sorter: RTL

- Downstream of the ALCT/CLCT/GEM position-matching stage.
- Opens a bx window when an ALCT/CLCT candidate set arrives and collects the per-cluster GEM and copad match vectors for the four ALCT×CLCT pairings.
- Picks the best pairing by fixed priority and reports it once per window with the winning cluster index.
- Output feeds the TMB LCT builder.

---
 rtl/gem_match_window_sorter_if.sv | 46 ++++
 rtl/gem_match_window_sorter.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/gem_match_window_sorter_if.sv
//==============================================================================
// Module : gem_match_window_sorter_if
// Desc   : Candidate-window handshake and match-vector bundle for the sorter.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

interface gem_match_window_sorter_if #(
   parameter int MXCLUSTER_CHAMBER = 8
);
   localparam int CLUSTER_W = (MXCLUSTER_CHAMBER > 1) ? $clog2(MXCLUSTER_CHAMBER) : 1;

   logic                         lct_start;
   logic                         match_valid;
   logic [MXCLUSTER_CHAMBER-1:0] a0c0_gem_match;
   logic [MXCLUSTER_CHAMBER-1:0] a0c1_gem_match;
   logic [MXCLUSTER_CHAMBER-1:0] a1c0_gem_match;
   logic [MXCLUSTER_CHAMBER-1:0] a1c1_gem_match;
   logic [MXCLUSTER_CHAMBER-1:0] a0c0_copad_match;
   logic [MXCLUSTER_CHAMBER-1:0] a0c1_copad_match;
   logic [MXCLUSTER_CHAMBER-1:0] a1c0_copad_match;
   logic [MXCLUSTER_CHAMBER-1:0] a1c1_copad_match;
   logic                         busy;
   logic                         best_vpf;
   logic [3:0]                   best_pri;
   logic [CLUSTER_W-1:0]         best_cluster;
   logic                         best_copad;
   logic                         best_nomatch;
   logic [7:0]                   drop_cnt;

   modport master (
      output lct_start, match_valid,
      output a0c0_gem_match, a0c1_gem_match, a1c0_gem_match, a1c1_gem_match,
      output a0c0_copad_match, a0c1_copad_match, a1c0_copad_match, a1c1_copad_match,
      input  busy, best_vpf, best_pri, best_cluster, best_copad, best_nomatch, drop_cnt
   );

   modport slave (
      input  lct_start, match_valid,
      input  a0c0_gem_match, a0c1_gem_match, a1c0_gem_match, a1c1_gem_match,
      input  a0c0_copad_match, a0c1_copad_match, a1c0_copad_match, a1c1_copad_match,
      output busy, best_vpf, best_pri, best_cluster, best_copad, best_nomatch, drop_cnt
   );
endinterface

`default_nettype wire

// File: rtl/gem_match_window_sorter.sv
//==============================================================================
// Module : gem_match_window_sorter
// Desc   : Collects ALCTxCLCT GEM/copad matches over a bx window, reports best.
//          Optional macro GEM_COPAD_EARLY_OUT_EN closes the window on a copad hit.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module gem_match_window_sorter #(
   parameter int WIN_BX            = 4,
   parameter int MXCLUSTER_CHAMBER = 8
) (
   input  wire logic                  clock,
   input  wire logic                  reset,
   gem_match_window_sorter_if.slave   bus
);
   localparam int CLUSTER_W = (MXCLUSTER_CHAMBER > 1) ? $clog2(MXCLUSTER_CHAMBER) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t                       state;
   state_t                       state_nxt;
   logic [2:0]                   win_cnt;
   logic [3:0]                   held_pri;
   logic [CLUSTER_W-1:0]         held_cluster;
   logic [MXCLUSTER_CHAMBER-1:0] vec [8];
   logic [3:0]                   cand_pri;
   logic [MXCLUSTER_CHAMBER-1:0] cand_vec;
   logic [CLUSTER_W-1:0]         cand_cluster;
   logic                         sample;
   logic                         take;
   logic                         win_last;
   logic                         early_out;
   logic [3:0]                   new_pri;
   logic [CLUSTER_W-1:0]         new_cluster;
   logic [3:0]                   best_pri_q;
   logic [CLUSTER_W-1:0]         best_cluster_q;
   logic                         best_copad_q;
   logic                         best_nomatch_q;
   logic [7:0]                   drop_cnt_q;

   // Index i holds priority code i+1: copads first, then GEM-only, pair order a0c0..a1c1
   always_comb begin
      vec[0] = bus.a0c0_copad_match;
      vec[1] = bus.a0c1_copad_match;
      vec[2] = bus.a1c0_copad_match;
      vec[3] = bus.a1c1_copad_match;
      vec[4] = bus.a0c0_gem_match;
      vec[5] = bus.a0c1_gem_match;
      vec[6] = bus.a1c0_gem_match;
      vec[7] = bus.a1c1_gem_match;
   end

   always_comb begin
      cand_pri = 4'd0;
      cand_vec = '0;
      for (int i = 7; i >= 0; i--) begin
         if (|vec[i]) begin
            cand_pri = 4'(i + 1);
            cand_vec = vec[i];
         end
      end
   end

   always_comb begin
      cand_cluster = '0;
      for (int i = MXCLUSTER_CHAMBER - 1; i >= 0; i--) begin
         if (cand_vec[i]) cand_cluster = CLUSTER_W'(i);
      end
   end

   assign sample      = (state == WAIT) && bus.match_valid;
   assign take        = sample && (cand_pri != 4'd0) && ((held_pri == 4'd0) || (cand_pri < held_pri));
   assign new_pri     = take ? cand_pri : held_pri;
   assign new_cluster = take ? cand_cluster : held_cluster;
   assign win_last    = (win_cnt == 3'(WIN_BX - 1));

`ifdef GEM_COPAD_EARLY_OUT_EN
   assign early_out = sample && (cand_pri != 4'd0) && (cand_pri <= 4'd4);
`else
   assign early_out = 1'b0;
`endif

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (bus.lct_start) state_nxt = WAIT;
         WAIT:    if (early_out || win_last) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state          <= IDLE;
         win_cnt        <= 3'd0;
         held_pri       <= 4'd0;
         held_cluster   <= '0;
         best_pri_q     <= 4'd0;
         best_cluster_q <= '0;
         best_copad_q   <= 1'b0;
         best_nomatch_q <= 1'b0;
         drop_cnt_q     <= 8'd0;
      end else begin
         state <= state_nxt;
         if (state == WAIT) begin
            win_cnt      <= win_cnt + 3'd1;
            held_pri     <= new_pri;
            held_cluster <= new_cluster;
         end else begin
            win_cnt      <= 3'd0;
            held_pri     <= 4'd0;
            held_cluster <= '0;
         end
         // Result fields are captured on entry to DONE so they already include the last sampled bx
         if ((state == WAIT) && (state_nxt == DONE)) begin
            best_pri_q     <= new_pri;
            best_cluster_q <= new_cluster;
            best_copad_q   <= (new_pri != 4'd0) && (new_pri <= 4'd4);
            best_nomatch_q <= (new_pri == 4'd0);
         end
         if (bus.lct_start && (state != IDLE) && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_q <= drop_cnt_q + 8'd1;
         end
      end
   end

   assign bus.busy         = (state != IDLE);
   assign bus.best_vpf     = (state == DONE);
   assign bus.best_pri     = best_pri_q;
   assign bus.best_cluster = best_cluster_q;
   assign bus.best_copad   = best_copad_q;
   assign bus.best_nomatch = best_nomatch_q;
   assign bus.drop_cnt     = drop_cnt_q;

endmodule

`default_nettype wire
